// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: ALU-control decode plus a registered ALU, with
// iterative shift-add multiply and restoring divide that stall the pipeline.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [2:0]       ALUCtrl_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             stall_o,
  output logic             illegal_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] CTRL_AND  = 3'b000;
  localparam logic [2:0] CTRL_OR   = 3'b001;
  localparam logic [2:0] CTRL_ADD  = 3'b010;
  localparam logic [2:0] CTRL_MUL  = 3'b011;
  localparam logic [2:0] CTRL_DIVU = 3'b100;
  localparam logic [2:0] CTRL_SUB  = 3'b110;
  localparam logic [2:0] CTRL_SLT  = 3'b111;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic               valid_reg, valid_next;
  logic               illegal_reg, illegal_next;
  // a_reg: multiplicand (shifted left) or dividend/quotient shift register.
  // b_reg: multiplier (shifted right) or divisor.
  // acc_reg: product accumulator or partial remainder.
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic [WIDTH-1:0]   acc_reg, acc_next;
  logic               div_reg, div_next;

  logic [2:0]         ctrl_dec;
  logic               funct_ok;
  logic               illegal_dec;
  logic               is_multi;
  logic [WIDTH-1:0]   single_result;
  logic               stall_req;

  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [WIDTH-1:0]   a_step, b_step, acc_step, step_result;

  // ---------------------------------------------------------------- decode
  always_comb begin
    ctrl_dec = CTRL_ADD;
    funct_ok = 1'b1;
    case (ALUOp_i)
      2'b00: ctrl_dec = CTRL_ADD;
      2'b01: ctrl_dec = CTRL_SUB;
      2'b10: ctrl_dec = CTRL_OR;
      default: begin
        case (funct_i)
          6'b100000: ctrl_dec = CTRL_ADD;
          6'b100010: ctrl_dec = CTRL_SUB;
          6'b100100: ctrl_dec = CTRL_AND;
          6'b100101: ctrl_dec = CTRL_OR;
          6'b101010: ctrl_dec = CTRL_SLT;
          6'b011000: ctrl_dec = CTRL_MUL;
          6'b011011: ctrl_dec = CTRL_DIVU;
          default: begin
            ctrl_dec = CTRL_ADD;
            funct_ok = 1'b0;
          end
        endcase
      end
    endcase
  end

  assign illegal_dec = ~funct_ok;
  // Divide-by-zero short-circuits to the single-cycle path.
  assign is_multi = (ctrl_dec == CTRL_MUL) |
                    ((ctrl_dec == CTRL_DIVU) & (|data2_i));

  // ------------------------------------------------------ single-cycle ALU
  always_comb begin
    single_result = data1_i + data2_i;
    case (ctrl_dec)
      CTRL_AND:  single_result = data1_i & data2_i;
      CTRL_OR:   single_result = data1_i | data2_i;
      CTRL_SUB:  single_result = data1_i - data2_i;
      CTRL_SLT:  single_result = {{(WIDTH-1){1'b0}},
                                  ($signed(data1_i) < $signed(data2_i))};
      CTRL_DIVU: single_result = {WIDTH{1'b1}};
      default:   single_result = data1_i + data2_i;
    endcase
  end

  // ------------------------------------------------- iterative step datapath
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mul_addend
    assign mul_addend[gi] = a_reg[gi] & b_reg[0];
  end

  assign rem_shift = {acc_reg, a_reg[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, b_reg};

  always_comb begin
    a_step      = a_reg;
    b_step      = b_reg;
    acc_step    = acc_reg;
    step_result = acc_reg;
    if (div_reg) begin
      // Restoring step: keep the difference only when it did not go negative.
      acc_step    = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
      a_step      = {a_reg[WIDTH-2:0], ~rem_diff[WIDTH]};
      step_result = a_step;
    end else begin
      acc_step    = acc_reg + mul_addend;
      a_step      = {a_reg[WIDTH-2:0], 1'b0};
      b_step      = {1'b0, b_reg[WIDTH-1:1]};
      step_result = acc_step;
    end
  end

  // ------------------------------------------------- FSM next-state/outputs
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    result_next  = result_reg;
    valid_next   = 1'b0;
    illegal_next = 1'b0;
    a_next       = a_reg;
    b_next       = b_reg;
    acc_next     = acc_reg;
    div_next     = div_reg;
    stall_req    = 1'b0;

    if (flush_i) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (state_reg == IDLE) begin
      if (valid_i) begin
        illegal_next = illegal_dec;
        if (is_multi) begin
          state_next = BUSY;
          cnt_next   = '0;
          a_next     = data1_i;
          b_next     = data2_i;
          acc_next   = '0;
          div_next   = (ctrl_dec == CTRL_DIVU);
          stall_req  = 1'b1;
        end else begin
          result_next = single_result;
          valid_next  = 1'b1;
        end
      end
    end else begin
      a_next   = a_step;
      b_next   = b_step;
      acc_next = acc_step;
      cnt_next = cnt_reg + CNT_W'(1);
      if (cnt_reg == CNT_LAST) begin
        state_next  = IDLE;
        cnt_next    = '0;
        result_next = step_result;
        valid_next  = 1'b1;
      end else begin
        stall_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      result_reg  <= '0;
      valid_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      div_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      result_reg  <= result_next;
      valid_reg   <= valid_next;
      illegal_reg <= illegal_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      acc_reg     <= acc_next;
      div_reg     <= div_next;
    end
  end

  assign ALUCtrl_o = ctrl_dec;
  assign result_o  = result_reg;
  assign zero_o    = ~|result_reg;
  assign valid_o   = valid_reg;
  assign illegal_o = illegal_reg;
  assign stall_o   = stall_req & ~rst_i;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: a driver pushes model results, a
// negedge monitor pops and compares them whenever valid_o is seen.
module tb_alu_exec_unit;

  localparam int W = 32;

  typedef enum int {K_ADDI, K_SUBI, K_ORI, K_ADD, K_SUB, K_AND, K_OR,
                    K_SLT, K_MUL, K_DIVU, K_BAD} kind_t;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  funct = 6'b0;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic [2:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic        valid_out;
  logic        stall;
  logic        illegal;

  // Narrow instance for the WIDTH=8 checks.
  logic        v8 = 1'b0;
  logic        fl8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [5:0]  fn8 = 6'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [2:0]  ctrl8;
  logic [7:0]  r8;
  logic        z8, vo8, st8, il8;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_miss = 0;
  int          n_txn = 0;
  logic [31:0] last_res = '0;
  exp_t        sb[$];

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .flush_i(flush),
    .ALUOp_i(alu_op), .funct_i(funct), .data1_i(data1), .data2_i(data2),
    .ALUCtrl_o(alu_ctrl), .result_o(result), .zero_o(zero),
    .valid_o(valid_out), .stall_o(stall), .illegal_o(illegal)
  );

  alu_exec_unit #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .valid_i(v8), .flush_i(fl8),
    .ALUOp_i(op8), .funct_i(fn8), .data1_i(a8), .data2_i(b8),
    .ALUCtrl_o(ctrl8), .result_o(r8), .zero_o(z8),
    .valid_o(vo8), .stall_o(st8), .illegal_o(il8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------ reference model
  function automatic logic [31:0] ref_res(kind_t k, logic [31:0] a, logic [31:0] b);
    case (k)
      K_SUBI, K_SUB: return a - b;
      K_ORI, K_OR:   return a | b;
      K_AND:         return a & b;
      K_SLT:         return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      K_MUL:         return a * b;
      K_DIVU:        return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:       return a + b;
    endcase
  endfunction

  function automatic logic [2:0] ref_ctrl(kind_t k);
    case (k)
      K_SUBI, K_SUB: return 3'b110;
      K_ORI, K_OR:   return 3'b001;
      K_AND:         return 3'b000;
      K_SLT:         return 3'b111;
      K_MUL:         return 3'b011;
      K_DIVU:        return 3'b100;
      default:       return 3'b010;
    endcase
  endfunction

  function automatic bit is_multi(kind_t k, logic [31:0] b);
    return (k == K_MUL) || (k == K_DIVU && b != 0);
  endfunction

  task automatic apply(input kind_t k, input logic [31:0] a, input logic [31:0] b);
    data1  = a;
    data2  = b;
    funct  = 6'($urandom);
    alu_op = 2'b11;
    case (k)
      K_ADDI: alu_op = 2'b00;
      K_SUBI: alu_op = 2'b01;
      K_ORI:  alu_op = 2'b10;
      K_ADD:  funct = 6'b100000;
      K_SUB:  funct = 6'b100010;
      K_AND:  funct = 6'b100100;
      K_OR:   funct = 6'b100101;
      K_SLT:  funct = 6'b101010;
      K_MUL:  funct = 6'b011000;
      K_DIVU: funct = 6'b011011;
      default: begin
        case ($urandom_range(0, 3))
          0:       funct = 6'b000000;
          1:       funct = 6'b111111;
          2:       funct = 6'b100001;
          default: funct = 6'b011001;
        endcase
      end
    endcase
  endtask

  // Present one instruction, hold it while stalled, leave it on the bus as
  // the next cycle begins (the caller replaces it or idles).
  task automatic issue(input kind_t k, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   stalls;
    bit   m;
    apply(k, a, b);
    valid_in = 1'b1;
    m     = is_multi(k, b);
    e.res = ref_res(k, a, b);
    e.ill = (k == K_BAD);
    e.due = cyc + (m ? W + 1 : 1);
    sb.push_back(e);
    #1 chk("alu_ctrl", 32'(alu_ctrl), 32'(ref_ctrl(k)));
    stalls = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
      @(posedge clk);
      #1;
    end
    chk("stall_cycles", 32'(stalls), m ? 32'(W) : 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start a multi-cycle op and flush it in cycle k_cyc after presentation.
  task automatic flush_multi(input kind_t k, input logic [31:0] a,
                             input logic [31:0] b, input int k_cyc);
    apply(k, a, b);
    valid_in = 1'b1;
    repeat (k_cyc) begin
      @(posedge clk);
      #1;
    end
    chk("stall_before_flush", 32'(stall), (k_cyc - 1 != W - 1) ? 32'd1 : 32'd0);
    flush = 1'b1;
    #1 chk("stall_during_flush", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    valid_in = 1'b0;
    chk("result_after_flush", result, last_res);
    #1 chk("stall_after_flush", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic run8(input logic [1:0] aop, input logic [5:0] fn, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp_r, input int exp_lat,
                      input int exp_st, input logic [2:0] exp_c);
    int n0, stalls, lat;
    bit got, hold;
    op8 = aop; fn8 = fn; a8 = a; b8 = b; v8 = 1'b1;
    n0 = cyc; stalls = 0; lat = -1; got = 1'b0; hold = 1'b1;
    #1 chk("w8_alu_ctrl", 32'(ctrl8), 32'(exp_c));
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (vo8) begin
        got = 1'b1;
        lat = cyc - n0;
        chk("w8_result", 32'(r8), 32'(exp_r));
        chk("w8_zero", 32'(z8), (exp_r == 0) ? 32'd1 : 32'd0);
      end
      if (st8) stalls++;
      else hold = 1'b0;
      @(posedge clk);
      #1;
      if (!hold) v8 = 1'b0;
    end
    chk("w8_latency", 32'(lat), 32'(exp_lat));
    chk("w8_stall_cycles", 32'(stalls), 32'(exp_st));
  endtask

  // -------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_out) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_miss++;
          $display("FAIL unexpected_valid: got result 0x%0h, want no valid_o (cycle %0d)",
                   result, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_txn++;
          $display("txn %0d cycle %0d: result 0x%08h expect 0x%08h illegal %0b",
                   n_txn, cyc, result, e.res, illegal);
          chk("result", result, e.res);
          chk("zero", 32'(zero), (e.res == 0) ? 32'd1 : 32'd0);
          chk("illegal", 32'(illegal), 32'(e.ill));
          chk("latency_cycle", 32'(cyc), 32'(e.due));
          last_res = e.res;
        end
      end else begin
        chk("result_hold", result, last_res);
        if (illegal) chk("illegal_without_valid", 32'(illegal), 32'd0);
      end
    end
  end

  // --------------------------------------------------------------- driver
  initial begin
    apply(K_MUL, 32'd7, 32'd9);
    valid_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_stall_forced_low", 32'(stall), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    valid_in = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply.
    issue(K_ADDI, 32'd2, 32'd3);
    apply(K_MUL, 32'd7, 32'd9);
    valid_in = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("stall_busy_pre_reset", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    valid_in = 1'b0;
    last_res = '0;
    #1;
    chk("midbusy_rst_result", result, 32'd0);
    chk("midbusy_rst_zero", 32'(zero), 32'd1);
    chk("midbusy_rst_valid", 32'(valid_out), 32'd0);
    chk("midbusy_rst_stall", 32'(stall), 32'd0);
    chk("midbusy_rst_illegal", 32'(illegal), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(K_MUL, 32'd7, 32'd9);

    // Back-to-back single-cycle stream.
    issue(K_ADD, 32'hFFFF_FFFF, 32'd1);
    issue(K_SUB, 32'd3, 32'd5);
    issue(K_SLT, 32'hFFFF_FFFF, 32'd1);
    issue(K_ORI, 32'h0000_00F0, 32'h0000_000F);
    issue(K_SLT, 32'd1, 32'hFFFF_FFFF);
    issue(K_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);

    // Multiply and divide, including back-to-back with a following add.
    issue(K_MUL, 32'h0001_0000, 32'h0001_0000);
    issue(K_MUL, 32'hFFFF_FFFF, 32'd2);
    issue(K_DIVU, 32'd100, 32'd7);
    issue(K_DIVU, 32'd5, 32'd0);
    issue(K_DIVU, 32'hFFFF_FFFF, 32'd1);
    issue(K_ADD, 32'd10, 32'd20);
    idle(1);

    // Flush mid-BUSY, on the completion edge, and on a single-cycle accept.
    flush_multi(K_MUL, 32'd123, 32'd456, 11);
    flush_multi(K_DIVU, 32'd1000, 32'd3, W);
    apply(K_ADD, 32'd1, 32'd1);
    valid_in = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    apply(K_MUL, 32'd3, 32'd3);
    flush = 1'b1;
    #1 chk("stall_idle_flush", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    valid_in = 1'b0;
    chk("result_after_accept_flush", result, last_res);
    @(posedge clk);
    #1;
    issue(K_MUL, 32'd11, 32'd13);

    // Unknown funct, then a legal op so the pulse must drop.
    issue(K_BAD, 32'd1, 32'd2);
    issue(K_ADD, 32'd4, 32'd4);
    idle(1);

    for (int i = 0; i < 80; i++) begin
      kind_t k;
      k = kind_t'($urandom_range(0, 10));
      issue(k, rnd_operand(), rnd_operand());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(W + 6);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    run8(2'b11, 6'b011000, 8'd15, 8'd17, 8'hFF, 9, 8, 3'b011);
    run8(2'b11, 6'b011011, 8'd100, 8'd7, 8'd14, 9, 8, 3'b100);
    run8(2'b11, 6'b011011, 8'd5, 8'd0, 8'hFF, 1, 0, 3'b100);
    run8(2'b00, 6'b000000, 8'd200, 8'd100, 8'd44, 1, 0, 3'b010);
    run8(2'b11, 6'b011000, 8'hFF, 8'd2, 8'hFE, 9, 8, 3'b011);
    run8(2'b11, 6'b011000, 8'h10, 8'h10, 8'h00, 9, 8, 3'b011);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
